// File: rtl/shift_right_tx_ctrl_pkg.sv
// Shared definitions for the right-shift serial transmitter.
package shift_right_tx_ctrl_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_right_reg_ld.sv
// Loadable right-shift register; load wins over shift, otherwise hold.
module shift_right_reg_ld #(
  parameter int   WIDTH    = 4,
  parameter logic FILL_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // next register contents: load > shift > hold
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (shift_en) begin
      q_d = {FILL_BIT, q_q[WIDTH-1:1]};
    end
  end

  // register with async active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/shift_right_tx_ctrl.sv
// Parallel-to-serial transmitter controller: handshake, FSM, bit counter.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   S_IDLE  | ready for a word; in_valid loads the shifter
//   S_SHIFT | serial_out carries Q[0]; one bit per unstalled cycle
//   S_DONE  | one-cycle done pulse, then back to S_IDLE
module shift_right_tx_ctrl
  import shift_right_tx_ctrl_pkg::*;
#(
  parameter int   WIDTH    = DEF_WIDTH,
  parameter logic FILL_BIT = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       stall,
  output logic                       serial_out,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       done
);

  localparam int CNT_W = $clog2(WIDTH+1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             load;
  logic             shift_en;
  logic [WIDTH-1:0] shreg;

  shift_right_reg_ld #(
    .WIDTH    (WIDTH),
    .FILL_BIT (FILL_BIT)
  ) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift_en (shift_en),
    .d        (in_data),
    .Q        (shreg)
  );

  // next-state, counter update and output decode
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (!stall) begin
          shift_en  = 1'b1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_CNT) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign serial_out = shreg[0];
  assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_shift_right_tx_ctrl.sv
// Directed bench for shift_right_tx_ctrl (WIDTH=4, FILL_BIT=0).
module tb_shift_right_tx_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       stall;
  logic       serial_out;
  logic       busy;
  logic [2:0] bit_cnt;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  shift_right_tx_ctrl #(.WIDTH(4), .FILL_BIT(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .stall      (stall),
    .serial_out (serial_out),
    .busy       (busy),
    .bit_cnt    (bit_cnt),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one word from an IDLE cycle and checks every cycle up to the
  // following IDLE cycle. Bit stall_at is held for stall_len extra cycles.
  // With keep_valid, in_valid stays high carrying next_data after acceptance.
  task automatic tx(input string tag, input logic [3:0] word, input int stall_at,
                    input int stall_len, input logic keep_valid, input logic [3:0] next_data);
    chk({tag, " idle_ready"}, in_ready, 1);
    chk({tag, " idle_busy"}, busy, 0);
    in_valid = 1'b1;
    in_data  = word;
    step();
    in_valid = keep_valid;
    in_data  = next_data;
    for (int i = 0; i < 4; i++) begin
      int extra;
      extra = (i == stall_at) ? stall_len : 0;
      for (int s = 0; s <= extra; s++) begin
        stall = (s < extra);
        chk($sformatf("%s bit%0d_%0d", tag, i, s), serial_out, word[i]);
        chk($sformatf("%s busy%0d_%0d", tag, i, s), busy, 1);
        chk($sformatf("%s cnt%0d_%0d", tag, i, s), bit_cnt, i);
        chk($sformatf("%s nrdy%0d_%0d", tag, i, s), in_ready, 0);
        chk($sformatf("%s nodone%0d_%0d", tag, i, s), done, 0);
        step();
      end
    end
    stall = 1'b0;
    chk({tag, " done"}, done, 1);
    chk({tag, " done_cnt"}, bit_cnt, 4);
    chk({tag, " done_nrdy"}, in_ready, 0);
    chk({tag, " done_busy"}, busy, 0);
    step();
    chk({tag, " post_done"}, done, 0);
    chk({tag, " post_ready"}, in_ready, 1);
    chk({tag, " post_cnt"}, bit_cnt, 4);
    chk({tag, " post_ser"}, serial_out, 0);
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
    stall    = 1'b0;

    // 1: reset held for 2 cycles, released mid-clock
    step();
    step();
    chk("rst in_ready", in_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst serial_out", serial_out, 0);
    chk("rst bit_cnt", bit_cnt, 0);
    #3 reset = 1'b1;
    step();
    chk("rst idle hold", in_ready, 1);

    // 2: basic transfer -> 1,1,0,1 then done
    tx("basic", 4'b1011, -1, 0, 1'b0, 4'h0);

    // 3: two stall cycles on the first bit -> 0,0,0,1,1,0
    tx("stall", 4'b0110, 0, 2, 1'b0, 4'h0);

    // 4: 4'b1111 offered throughout the shift of 4'b1000, accepted afterwards
    tx("ign", 4'b1000, -1, 0, 1'b1, 4'b1111);
    tx("ign_next", 4'b1111, -1, 0, 1'b0, 4'h0);

    // 5: reset after two bits of 4'b1101
    in_valid = 1'b1;
    in_data  = 4'b1101;
    step();
    in_valid = 1'b0;
    chk("abort bit0", serial_out, 1);
    step();
    chk("abort bit1", serial_out, 0);
    step();
    chk("abort bit2", serial_out, 1);
    chk("abort cnt2", bit_cnt, 2);
    reset = 1'b0;
    #1;
    chk("abort in_ready", in_ready, 1);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort serial_out", serial_out, 0);
    chk("abort bit_cnt", bit_cnt, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("abort nodone%0d", k), done, 0);
    end
    #2 reset = 1'b1;
    step();
    chk("abort idle", in_ready, 1);
    tx("after_abort", 4'b1101, -1, 0, 1'b0, 4'h0);

    // 6: back-to-back with in_valid held high
    tx("b2b_a", 4'b1001, -1, 0, 1'b1, 4'b0011);
    tx("b2b_b", 4'b0011, -1, 0, 1'b0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
